// File: rtl/fir_output_pkg.sv
// Shared definitions for the FIR output stage.
//   OUT_WORD_WIDTH : width of each word presented to the SPI slave
//   state_t        : serialiser state (IDLE / PROC)
//   idx_width()    : width of a sample index for a given packet size, at least 1
package fir_output_pkg;

    localparam int OUT_WORD_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        PROC = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational conversion of one signed filter result into a 32-bit output word.
// The sample is rounded half up, arithmetically shifted right by SHIFT, clamped
// to a signed SAT_WIDTH range and sign-extended to OUT_WORD_WIDTH bits.
//   sample  in  IN_WIDTH        signed filter result
//   word    out OUT_WORD_WIDTH  converted, sign-extended result
//   clamped out 1               high when the result was saturated
module fir_round_sat
    import fir_output_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int SHIFT     = 15,
    parameter int SAT_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0]       sample,
    output logic [OUT_WORD_WIDTH-1:0] word,
    output logic                      clamped
);

    // One guard bit keeps the rounding add from overflowing.
    localparam int EW = IN_WIDTH + 1;
    // Compare in a width that holds both the shifted value and the clamp limits.
    localparam int CW = (EW > OUT_WORD_WIDTH + 1) ? EW : OUT_WORD_WIDTH + 1;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [EW-1:0] RND_BIAS = (SHIFT > 0) ? (EW'(1) << RND_POS) : '0;
    localparam logic signed [CW-1:0] SAT_MAX = $signed((CW'(1) << (SAT_WIDTH - 1)) - CW'(1));
    // Bitwise inverse of 2^(n-1)-1 is -2^(n-1).
    localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [EW-1:0] extended;
    logic signed [EW-1:0] rounded;
    logic signed [EW-1:0] shifted;
    logic signed [CW-1:0] wide;
    logic signed [CW-1:0] limited;

    // NOTE: combinational logic uses blocking assignments, and every output gets a
    // default before any branch so no latch is inferred.
    always_comb begin
        extended = $signed({sample[IN_WIDTH-1], sample});
        rounded  = extended + $signed(RND_BIAS);
        shifted  = rounded >>> SHIFT;
        wide     = CW'(shifted);
        limited  = wide;
        clamped  = 1'b0;
        if (wide > SAT_MAX) begin
            limited = SAT_MAX;
            clamped = 1'b1;
        end else if (wide < SAT_MIN) begin
            limited = SAT_MIN;
            clamped = 1'b1;
        end
        // The limited value fits in SAT_WIDTH <= 32 bits, so truncation is a sign extension.
        word = OUT_WORD_WIDTH'(limited);
    end

endmodule

// File: rtl/fir_output_stage.sv
// Output stage of the FIR filter. Captures a parallel block of results on doneIn,
// converts one sample per clock into a work buffer, and swaps that buffer into
// the TX-facing buffer on each SPI packet boundary.
//   clk           in   system clock
//   nResetIn      in   asynchronous active-low reset
//   doneIn        in   pulse, dataIn valid
//   dataIn        in   IN_WIDTH*SAMPLES_NUM results, sample 0 in the MSBs
//   packetSwapIn  in   pulse at SPI packet completion
//   clearFlagsIn  in   clears the sticky flags
//   txDataOut     out  32*SAMPLES_NUM words to the SPI slave, sample 0 in the MSBs
//   busyOut       out  high while serialising
//   pendingOut    out  work buffer holds an unconsumed block
//   overrunOut    out  sticky: a block arrived while busy or while one was pending
//   underrunOut   out  sticky: a swap found no pending block
//   satFlagOut    out  sticky: a sample was clamped
module fir_output_stage
    import fir_output_pkg::*;
#(
    parameter int SAMPLES_NUM = 8,
    parameter int IN_WIDTH    = 32,
    parameter int SHIFT       = 15,
    parameter int SAT_WIDTH   = 16
) (
    input  logic                                clk,
    input  logic                                nResetIn,
    input  logic                                doneIn,
    input  logic [IN_WIDTH*SAMPLES_NUM-1:0]     dataIn,
    input  logic                                packetSwapIn,
    input  logic                                clearFlagsIn,
    output logic [OUT_WORD_WIDTH*SAMPLES_NUM-1:0] txDataOut,
    output logic                                busyOut,
    output logic                                pendingOut,
    output logic                                overrunOut,
    output logic                                underrunOut,
    output logic                                satFlagOut
);

    localparam int IDX_W = idx_width(SAMPLES_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_NUM - 1);

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [IN_WIDTH-1:0]       in_reg   [SAMPLES_NUM];
    logic [OUT_WORD_WIDTH-1:0] work_buf [SAMPLES_NUM];
    logic [OUT_WORD_WIDTH-1:0] tx_buf   [SAMPLES_NUM];
    logic                      pending;
    logic                      overrun;
    logic                      underrun;
    logic                      sat_flag;

    logic [OUT_WORD_WIDTH-1:0] cur_word;
    logic                      cur_clamp;
    logic                      in_proc;

    assign in_proc = (state == PROC);

    fir_round_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .SHIFT     (SHIFT),
        .SAT_WIDTH (SAT_WIDTH)
    ) u_round_sat (
        .sample  (in_reg[idx]),
        .word    (cur_word),
        .clamped (cur_clamp)
    );

    always_ff @(posedge clk or negedge nResetIn) begin
        if (!nResetIn) begin
            state    <= IDLE;
            idx      <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
            sat_flag <= 1'b0;
            // NOTE: the buffers are reset too, so an aborted block leaves no stale
            // data behind; this costs reset fan-out but is a hard requirement here.
            for (int i = 0; i < SAMPLES_NUM; i++) begin
                in_reg[i]   <= '0;
                work_buf[i] <= '0;
                tx_buf[i]   <= '0;
            end
        end else begin
            // The swap copies the work buffer as it stood before this edge.
            if (packetSwapIn && pending) begin
                for (int i = 0; i < SAMPLES_NUM; i++) begin
                    tx_buf[i] <= work_buf[i];
                end
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (doneIn) begin
                        for (int i = 0; i < SAMPLES_NUM; i++) begin
                            in_reg[i] <= dataIn[(SAMPLES_NUM-1-i)*IN_WIDTH +: IN_WIDTH];
                        end
                        idx   <= '0;
                        state <= PROC;
                    end
                end
                PROC: begin
                    work_buf[idx] <= cur_word;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        // NOTE: sequential state uses non-blocking assignments; the last
                        // one in the block wins, so a completing block stays pending
                        // even when a swap cleared pending in the same cycle.
                        pending <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Sticky flags: a set condition beats a simultaneous clear.
            overrun  <= (overrun  & ~clearFlagsIn) | (doneIn & (in_proc | pending));
            underrun <= (underrun & ~clearFlagsIn) | (packetSwapIn & ~pending);
            sat_flag <= (sat_flag & ~clearFlagsIn) | (in_proc & cur_clamp);
        end
    end

    for (genvar g = 0; g < SAMPLES_NUM; g++) begin : g_tx_pack
        assign txDataOut[(SAMPLES_NUM-1-g)*OUT_WORD_WIDTH +: OUT_WORD_WIDTH] = tx_buf[g];
    end

    assign busyOut     = in_proc;
    assign pendingOut  = pending;
    assign overrunOut  = overrun;
    assign underrunOut = underrun;
    assign satFlagOut  = sat_flag;

endmodule

// File: tb/tb_fir_output_stage.sv
// Self-checking bench for fir_output_stage: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level reference model.
module tb_fir_output_stage;

    localparam int N  = 8;
    localparam int IW = 32;
    localparam int SH = 15;
    localparam int SW = 16;
    localparam int TW = 32 * N;

    logic          clk = 1'b0;
    logic          nResetIn;
    logic          doneIn;
    logic [IW*N-1:0] dataIn;
    logic          packetSwapIn;
    logic          clearFlagsIn;
    logic [TW-1:0] txDataOut;
    logic          busyOut;
    logic          pendingOut;
    logic          overrunOut;
    logic          underrunOut;
    logic          satFlagOut;

    int checks = 0;
    int errors = 0;

    fir_output_stage #(
        .SAMPLES_NUM (N),
        .IN_WIDTH    (IW),
        .SHIFT       (SH),
        .SAT_WIDTH   (SW)
    ) dut (
        .clk          (clk),
        .nResetIn     (nResetIn),
        .doneIn       (doneIn),
        .dataIn       (dataIn),
        .packetSwapIn (packetSwapIn),
        .clearFlagsIn (clearFlagsIn),
        .txDataOut    (txDataOut),
        .busyOut      (busyOut),
        .pendingOut   (pendingOut),
        .overrunOut   (overrunOut),
        .underrunOut  (underrunOut),
        .satFlagOut   (satFlagOut)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_proc;
    int          m_idx;
    logic [31:0] m_blk [N];
    bit          m_blk_clamp [N];
    logic [31:0] m_work [N];
    logic [31:0] m_tx [N];
    bit          m_pend, m_over, m_under, m_sat;

    // Plain integer arithmetic: round half up, shift, clamp.
    function automatic logic [31:0] convert(input logic [31:0] x, output bit clamped);
        longint v, hi, lo;
        v  = longint'($signed(x));
        v  = v + (longint'(1) <<< (SH - 1));
        v  = v >>> SH;
        hi = (longint'(1) <<< (SW - 1)) - 1;
        lo = -(longint'(1) <<< (SW - 1));
        clamped = 1'b0;
        if (v > hi) begin
            v = hi;
            clamped = 1'b1;
        end else if (v < lo) begin
            v = lo;
            clamped = 1'b1;
        end
        return v[31:0];
    endfunction

    task automatic model_reset();
        m_proc = 0; m_idx = 0; m_pend = 0; m_over = 0; m_under = 0; m_sat = 0;
        for (int i = 0; i < N; i++) begin
            m_blk[i] = '0; m_blk_clamp[i] = 0; m_work[i] = '0; m_tx[i] = '0;
        end
    endtask

    task automatic model_cycle(input bit done, input logic [IW*N-1:0] data,
                               input bit swap, input bit clear);
        bit was_pend;
        bit c;
        was_pend = m_pend;
        if (clear) begin
            m_over = 0; m_under = 0; m_sat = 0;
        end
        if (swap) begin
            if (was_pend) begin
                for (int i = 0; i < N; i++) m_tx[i] = m_work[i];
                m_pend = 0;
            end else begin
                m_under = 1;
            end
        end
        if (m_proc) begin
            m_work[m_idx] = m_blk[m_idx];
            if (m_blk_clamp[m_idx]) m_sat = 1;
            if (done) m_over = 1;
            if (m_idx == N - 1) begin
                m_proc = 0;
                m_pend = 1;
            end else begin
                m_idx++;
            end
        end else if (done) begin
            for (int i = 0; i < N; i++) begin
                m_blk[i] = convert(data[(N-1-i)*32 +: 32], c);
                m_blk_clamp[i] = c;
            end
            m_idx  = 0;
            m_proc = 1;
            if (was_pend) m_over = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [TW-1:0] observed,
                         input logic [TW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic compare_all();
        logic [TW-1:0] exp_tx;
        for (int i = 0; i < N; i++) exp_tx[(N-1-i)*32 +: 32] = m_tx[i];
        check("txData",   txDataOut,   exp_tx);
        check("busy",     TW'(busyOut),     TW'(m_proc));
        check("pending",  TW'(pendingOut),  TW'(m_pend));
        check("overrun",  TW'(overrunOut),  TW'(m_over));
        check("underrun", TW'(underrunOut), TW'(m_under));
        check("satflag",  TW'(satFlagOut),  TW'(m_sat));
    endtask

    // Drives one cycle of inputs, advances the model, samples 1 ns after the edge.
    task automatic step(input bit done, input logic [IW*N-1:0] data,
                        input bit swap, input bit clear);
        doneIn = done; dataIn = data; packetSwapIn = swap; clearFlagsIn = clear;
        model_cycle(done, data, swap, clear);
        @(posedge clk);
        #1;
        doneIn = 0; packetSwapIn = 0; clearFlagsIn = 0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, dataIn, 1'b0, 1'b0);
    endtask

    function automatic logic [IW*N-1:0] rand_block();
        logic [IW*N-1:0] b;
        logic [31:0] s;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 2))
                0:       s = $urandom;
                1:       s = 32'($signed($urandom_range(0, 262143)) - 131072);
                default: s = 32'($signed($urandom_range(0, 2097151)) - 1048576);
            endcase
            b[(N-1-i)*32 +: 32] = s;
        end
        return b;
    endfunction

    logic [IW*N-1:0] blk_a, blk_b;
    logic [TW-1:0]   exp1;

    initial begin
        nResetIn = 0; doneIn = 0; packetSwapIn = 0; clearFlagsIn = 0; dataIn = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        nResetIn = 1;

        // Known vectors: conversion, latency, saturation.
        blk_a = {32'h00010000, 32'h00004000, 32'hFFFFC000, 32'h7FFFFFFF,
                 32'h80000000, 32'h00000000, 32'hFFFF0000, 32'h00000001};
        exp1  = {32'h00000002, 32'h00000001, 32'h00000000, 32'h00007FFF,
                 32'hFFFF8000, 32'h00000000, 32'hFFFFFFFE, 32'h00000000};
        step(1'b1, blk_a, 1'b0, 1'b0);           // cycle 0
        check("busy_c1", TW'(busyOut), TW'(1));
        idle(7);                                  // now cycle 8
        check("pend_c8", TW'(pendingOut), TW'(0));
        idle(1);                                  // now cycle 9
        check("pend_c9", TW'(pendingOut), TW'(1));
        check("busy_c9", TW'(busyOut), TW'(0));
        check("tx_before_swap", txDataOut, TW'(0));
        idle(3);                                  // now cycle 12
        step(1'b0, blk_a, 1'b1, 1'b0);
        check("tx_vectors", txDataOut, exp1);
        check("sat_vectors", TW'(satFlagOut), TW'(1));

        // doneIn during PROC: dropped, overrun set, first block delivered.
        step(1'b0, dataIn, 1'b0, 1'b1);
        blk_a = rand_block();
        blk_b = rand_block();
        step(1'b1, blk_a, 1'b0, 1'b0);
        idle(2);
        step(1'b1, blk_b, 1'b0, 1'b0);
        check("overrun_proc", TW'(overrunOut), TW'(1));
        idle(6);
        step(1'b0, dataIn, 1'b1, 1'b0);

        // Swap with nothing pending, then clear.
        step(1'b0, dataIn, 1'b1, 1'b0);
        check("underrun_set", TW'(underrunOut), TW'(1));
        step(1'b0, dataIn, 1'b0, 1'b1);
        check("underrun_clr", TW'(underrunOut), TW'(0));

        // Swap coincident with the final PROC write.
        blk_a = rand_block();
        step(1'b1, blk_a, 1'b0, 1'b0);
        idle(7);
        step(1'b0, dataIn, 1'b1, 1'b0);
        check("coinc_underrun", TW'(underrunOut), TW'(1));
        check("coinc_pending", TW'(pendingOut), TW'(1));
        step(1'b0, dataIn, 1'b1, 1'b0);
        check("coinc_next_pend", TW'(pendingOut), TW'(0));

        // Asynchronous reset mid-PROC, then a fresh block.
        step(1'b1, rand_block(), 1'b0, 1'b0);
        idle(3);
        nResetIn = 0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        nResetIn = 1;
        blk_b = rand_block();
        step(1'b1, blk_b, 1'b0, 1'b0);
        idle(8);
        step(1'b0, dataIn, 1'b1, 1'b0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 5) == 0, rand_block(),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time in case a wait never returns.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
